// File: rtl/stack_dmem_arbiter.sv
// rtl/stack_dmem_arbiter.sv - round-robin arbiter sharing one stack data memory port among NCORES cores
`ifndef STACK_ADDRW
`define STACK_ADDRW 10
`endif

module stack_dmem_arbiter #(
  parameter int NCORES      = 4,
  parameter int STACK_ADDRW = `STACK_ADDRW
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NCORES-1:0]             req_valid_i,
  output logic [NCORES-1:0]             req_ready_o,
  input  logic [NCORES-1:0]             req_we_i,
  input  logic [NCORES*STACK_ADDRW-1:0] req_addr_i,
  input  logic [NCORES*32-1:0]          req_wdata_i,
  input  logic [NCORES*4-1:0]           req_wstrb_i,
  output logic [NCORES-1:0]             rsp_valid_o,
  output logic [31:0]                   rsp_rdata_o,
  output logic                          mem_re_o,
  output logic                          mem_we_o,
  output logic [STACK_ADDRW-1:0]        mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_wstrb_o,
  input  logic [31:0]                   mem_rdata_i
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [PW-1:0] prio_q, prio_d;
  logic          rsp_pend_q, rsp_pend_d;
  logic [PW-1:0] rsp_id_q, rsp_id_d;
  logic          rsp_rd_q, rsp_rd_d;

  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;

  // First valid core at or after prio, wrapping modulo NCORES.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NCORES; i++) begin
      cand = PW'((int'(prio_q) + i) % NCORES);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    prio_d      = prio_q;
    rsp_pend_d  = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rd_d    = rsp_rd_q;
    if (gnt_found) begin
      req_ready_o[gnt_idx] = 1'b1;
      mem_we_o    = req_we_i[gnt_idx];
      mem_re_o    = ~req_we_i[gnt_idx];
      mem_addr_o  = req_addr_i[gnt_idx*STACK_ADDRW +: STACK_ADDRW];
      mem_wdata_o = req_wdata_i[gnt_idx*32 +: 32];
      mem_wstrb_o = req_we_i[gnt_idx] ? req_wstrb_i[gnt_idx*4 +: 4] : 4'b0000;
      prio_d      = (gnt_idx == PW'(NCORES - 1)) ? '0 : gnt_idx + 1'b1;
      rsp_pend_d  = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_rd_d    = ~req_we_i[gnt_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= '0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= '0;
      rsp_rd_q   <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
      rsp_rd_q   <= rsp_rd_d;
    end
  end

  // Write acknowledges carry zero data so only reads expose mem_rdata_i.
  always_comb begin
    rsp_valid_o = '0;
    if (rsp_pend_q) rsp_valid_o[rsp_id_q] = 1'b1;
    rsp_rdata_o = rsp_rd_q ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_stack_dmem_arbiter.sv
// tb/tb_stack_dmem_arbiter.sv - randomized and directed checks of stack_dmem_arbiter against a reference model
module tb_stack_dmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_wstrb = '0;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            mem_re, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic [31:0]     mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  stack_dmem_arbiter #(.NCORES(N), .STACK_ADDRW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered single-port memory seen by the arbiter.
  logic [31:0] mem [0:(1<<AW)-1];
  logic        mem_clr = 1'b1;
  logic        pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'h0;
    end else begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          m_prio = 0;
  bit          m_pend = 0;
  int          m_id = 0;
  bit          m_rd = 0;
  logic [31:0] m_rexp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    int g;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    logic [AW-1:0] a;
    logic [31:0] wd;
    logic [3:0] ws;
    bit we;
    if (!rst_n) begin
      m_prio = 0;
      m_pend = 0;
    end
    g = -1;
    for (int i = 0; i < N; i++) begin
      int k = (m_prio + i) % N;
      if (g < 0 && req_valid[k]) g = k;
    end
    er = '0; a = '0; wd = '0; ws = '0; we = 0;
    if (g >= 0) begin
      er[g] = 1'b1;
      we = req_we[g];
      a  = req_addr[g*AW +: AW];
      wd = req_wdata[g*32 +: 32];
      ws = we ? req_wstrb[g*4 +: 4] : 4'b0;
    end
    check("req_ready", 64'(req_ready), 64'(er));
    check("mem_re", 64'(mem_re), 64'(g >= 0 && !we));
    check("mem_we", 64'(mem_we), 64'(g >= 0 && we));
    check("mem_addr", 64'(mem_addr), 64'(a));
    check("mem_wdata", 64'(mem_wdata), 64'(wd));
    check("mem_wstrb", 64'(mem_wstrb), 64'(ws));
    ev = '0;
    if (m_pend) ev[m_id] = 1'b1;
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (m_pend) check("rsp_rdata", 64'(rsp_rdata), 64'(m_rd ? m_rexp : 32'h0));
    if (rst_n) begin
      if (g >= 0) begin
        m_pend = 1; m_id = g; m_rd = !we;
        if (!we) m_rexp = ref_mem[a];
        else for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        m_prio = (g + 1) % N;
      end else begin
        m_pend = 0;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit we, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    req_valid[k] = 1'b1;
    req_we[k] = we;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*32 +: 32] = wd;
    req_wstrb[k*4 +: 4] = ws;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    at_neg(); to_next();
    at_neg(); to_next();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] grant_s;
    int exp_g [6];
    exp_g = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 32'h0;

    // Contention straight out of reset.
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k + 1), 32'h0, 4'h0);
    at_neg();
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    to_next();
    mem_clr = 1'b0;
    at_neg(); to_next();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      check("contend_grant", 64'(req_ready), 64'(1 << exp_g[i]));
      if (i > 0) check("contend_rsp", 64'(rsp_valid), 64'(1 << exp_g[i-1]));
      to_next();
    end
    req_valid = '0;

    // Single read by core 2 of a preloaded word.
    do_reset();
    pre_en = 1'b1; pre_addr = AW'(16); pre_data = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    at_neg(); to_next();
    pre_en = 1'b0;
    set_req(2, 1'b0, AW'(16), 32'h0, 4'h0);
    at_neg();
    check("single_ready", 64'(req_ready), 64'b0100);
    check("single_re", 64'(mem_re), 64'h1);
    check("single_addr", 64'(mem_addr), 64'h10);
    to_next();
    req_valid = '0;
    at_neg();
    check("single_rsp", 64'(rsp_valid), 64'b0100);
    check("single_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    to_next();

    // Byte-strobed writes from core 1 then read back.
    set_req(1, 1'b1, AW'(32), 32'h11223344, 4'b1111);
    at_neg(); to_next();
    set_req(1, 1'b1, AW'(32), 32'hAA000000, 4'b1000);
    at_neg();
    check("wr1_ack", 64'(rsp_valid), 64'b0010);
    check("wr1_data", 64'(rsp_rdata), 64'h0);
    to_next();
    set_req(1, 1'b0, AW'(32), 32'h0, 4'h0);
    at_neg();
    check("wr2_ack", 64'(rsp_valid), 64'b0010);
    check("wr2_data", 64'(rsp_rdata), 64'h0);
    to_next();
    req_valid = '0;
    at_neg();
    check("byte_read", 64'(rsp_rdata), 64'hAA223344);
    to_next();

    // Skip idle cores: put prio on core 1, then only cores 0 and 3 request.
    set_req(0, 1'b0, AW'(3), 32'h0, 4'h0);
    at_neg(); to_next();
    set_req(3, 1'b0, AW'(4), 32'h0, 4'h0);
    at_neg();
    check("skip_first", 64'(req_ready), 64'b1000);
    to_next();
    req_valid[3] = 1'b0;
    at_neg();
    check("skip_second", 64'(req_ready), 64'b0001);
    to_next();
    req_valid = '0;
    set_req(1, 1'b0, AW'(5), 32'h0, 4'h0);
    set_req(0, 1'b0, AW'(6), 32'h0, 4'h0);
    at_neg();
    check("skip_prio1", 64'(req_ready), 64'b0010);
    to_next();
    req_valid = '0;

    // Idle: prio is 2 and must stay there.
    for (int i = 0; i < 10; i++) begin
      at_neg();
      check("idle_en", 64'({mem_re, mem_we, mem_wstrb}), 64'h0);
      to_next();
    end
    req_valid = '1;
    req_we = '0;
    at_neg();
    check("idle_prio", 64'(req_ready), 64'b0100);
    to_next();
    req_valid = '0;

    // Async reset while a read response is pending.
    set_req(2, 1'b0, AW'(16), 32'h0, 4'h0);
    at_neg(); to_next();
    req_valid = '0;
    check("pre_reset_rsp", 64'(rsp_valid), 64'b0100);
    #2 rst_n = 1'b0;
    #1 check("async_drop", 64'(rsp_valid), 64'h0);
    set_req(3, 1'b0, AW'(7), 32'h0, 4'h0);
    set_req(0, 1'b0, AW'(8), 32'h0, 4'h0);
    at_neg(); to_next();
    rst_n = 1'b1;
    at_neg();
    check("post_reset_grant", 64'(req_ready), 64'b0001);
    to_next();
    req_valid = '0;

    // Randomized traffic with hold-until-granted requesters.
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      grant_s = req_ready;
      to_next();
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && !grant_s[k]) continue;
        if ($urandom_range(99) < 45)
          set_req(k, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom, 4'($urandom));
        else
          req_valid[k] = 1'b0;
      end
    end
    req_valid = '0;
    at_neg(); to_next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
